// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: synced sources, edge/level pending, mask, priority, ack/EOI FSM
module irq_ctrl #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  src,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic [1:0]       reg_sel,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_n;
  logic             irq_n;
  logic [VEC_W-1:0] vec_n, best;
  logic [NSRC-1:0]  s1, s2, sprev;
  logic [NSRC-1:0]  pend, mask, mode;
  logic [NSRC-1:0]  pend_n, mode_n, elig, w1c, ack_clr;
  logic [15:0]      rd_word;
  logic             wr_mask, wr_pend, wr_mode, wr_vec, ack_take;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign wr_mask  = reg_wr && (reg_sel == 2'd0);
  assign wr_pend  = reg_wr && (reg_sel == 2'd1);
  assign wr_mode  = reg_wr && (reg_sel == 2'd2);
  assign wr_vec   = reg_wr && (reg_sel == 2'd3);
  assign ack_take = (state == REQ) && irq_ack;

  // The new MODE value is used in the write cycle so an edge->level switch
  // drops the latched bit immediately and PEND tracks the level from then on.
  always_comb begin
    mode_n  = wr_mode ? reg_wdata[NSRC-1:0] : mode;
    w1c     = wr_pend ? reg_wdata[NSRC-1:0] : '0;
    ack_clr = ack_take ? (NSRC'(1) << irq_vec) : '0;
    pend_n  = (mode_n & s2) |
              (~mode_n & ((pend & ~w1c & ~ack_clr) | (s2 & ~sprev)));
  end

  assign elig = pend & mask;

  always_comb begin
    best = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) best = VEC_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    irq_n   = irq;
    vec_n   = irq_vec;
    case (state)
      IDLE: begin
        irq_n = 1'b0;
        if (|elig) begin
          state_n = REQ;
          irq_n   = 1'b1;
          vec_n   = best;
        end
      end
      REQ: begin
        // Ack wins over re-evaluation: the vector stays at what the CPU took.
        if (irq_ack) begin
          state_n = SERVICE;
          irq_n   = 1'b0;
        end else if (!(|elig)) begin
          state_n = IDLE;
          irq_n   = 1'b0;
        end else begin
          vec_n = best;
        end
      end
      SERVICE: begin
        irq_n = 1'b0;
        if (wr_vec) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      2'd0: rd_word = 16'(mask);
      2'd1: rd_word = 16'(pend);
      2'd2: rd_word = 16'(mode);
      default: begin
        rd_word[VEC_W-1:0] = irq_vec;
        rd_word[14]        = (state == REQ);
        rd_word[15]        = (state == SERVICE);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_vec   <= '0;
      reg_rdata <= '0;
      s1        <= '0;
      s2        <= '0;
      sprev     <= '0;
      pend      <= '0;
      mask      <= '0;
      mode      <= '0;
    end else begin
      state   <= state_n;
      irq     <= irq_n;
      irq_vec <= vec_n;
      s1      <= src;
      s2      <= s1;
      sprev   <= s2;
      pend    <= pend_n;
      mode    <= mode_n;
      if (wr_mask) mask <= reg_wdata[NSRC-1:0];
      if (reg_rd) reg_rdata <= rd_word;
    end
  end

endmodule
